// File: rtl/cpu_prefetch.sv
// Instruction prefetch queue: fetches bytes at CS:IP into a DEPTH-byte FIFO for the decoder.
// Optional same-cycle bypass of an acked byte into an empty queue: define PREFETCH_BYPASS_EN.
module cpu_prefetch #(
  parameter int unsigned DEPTH = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [15:0] flush_cs,
  input  logic [15:0] flush_ip,
  input  logic        bus_busy,
  output logic [19:0] mem_address,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  q_data,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [15:0] q_ip
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state_q;
  logic [15:0]     fetch_cs_q;
  logic [15:0]     fetch_ip_q;
  logic [15:0]     q_ip_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      q_data_q;
  logic [7:0]      q_data_d;
  logic            q_valid_q;
  logic            ack_c;
  logic            bypass_c;
  logic            push_c;
  logic            pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign mem_address = {fetch_cs_q, 4'h0} + 20'(fetch_ip_q);
  assign mem_req     = (state_q == FETCH);
  assign q_ip        = q_ip_q;
  assign ack_c       = (state_q == FETCH) && mem_ack && !flush;

`ifdef PREFETCH_BYPASS_EN
  // An acked byte arriving at an empty queue is offered to the decoder immediately
  assign bypass_c = ack_c && (count_q == '0) && q_ready;
  assign q_valid  = q_valid_q || (ack_c && (count_q == '0));
  assign q_data   = q_valid_q ? q_data_q : mem_data;
`else
  assign bypass_c = 1'b0;
  assign q_valid  = q_valid_q;
  assign q_data   = q_data_q;
`endif

  assign push_c = ack_c && !bypass_c;
  assign pop_c  = q_valid_q && q_ready && !flush;

  // Next occupancy and next head byte; q_data_q always mirrors the head slot
  always_comb begin
    count_d  = count_q;
    q_data_d = q_data_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (pop_c) begin
        if (count_q == CW'(1)) begin
          if (push_c) q_data_d = mem_data;
        end else begin
          q_data_d = buf_q[ptr_inc(head_q)];
        end
      end else if (push_c && (count_q == '0)) begin
        q_data_d = mem_data;
      end
    end
  end

  // Control, pointers and fetch FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_cs_q <= 16'hFFFF;
      fetch_ip_q <= 16'h0000;
      q_ip_q     <= 16'h0000;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      q_data_q   <= 8'h00;
      q_valid_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      q_valid_q <= (count_d != '0);
      q_data_q  <= q_data_d;
      if (flush) begin
        state_q    <= IDLE;
        fetch_cs_q <= flush_cs;
        fetch_ip_q <= flush_ip;
        q_ip_q     <= flush_ip;
        head_q     <= '0;
        tail_q     <= '0;
      end else begin
        case (state_q)
          IDLE:    if ((count_q < CW'(DEPTH)) && !bus_busy) state_q <= FETCH;
          FETCH:   if (mem_ack) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
        if (ack_c)             fetch_ip_q <= fetch_ip_q + 16'd1;
        if (pop_c || bypass_c) q_ip_q     <= q_ip_q + 16'd1;
        if (push_c)            tail_q     <= ptr_inc(tail_q);
        if (pop_c)             head_q     <= ptr_inc(head_q);
      end
    end
  end

  // Byte storage needs no reset; occupancy alone qualifies it
  always_ff @(posedge clock) begin
    if (push_c) buf_q[tail_q] <= mem_data;
  end

endmodule
